// File: rtl/encoder_4x2_pkg.sv
// Shared constants for the 4-request grant encoder.
// ENCODER_4X2_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package encoder_4x2_pkg;

    localparam int NREQ   = 4;
    localparam int CODE_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [0:1] IDLE_CODE_DEF = 2'b00;

    // code[0] carries the index LSB, matching the decoder select order
    function automatic logic [0:1] idx_to_code(input logic [CODE_W-1:0] idx);
        logic [0:1] c;
        c[0] = idx[0];
        c[1] = idx[1];
        return c;
    endfunction

endpackage

// File: rtl/encoder_4x2_prio_pick4.sv
// Combinational 4-way picker: first set request at or after start, wrapping.
// Inverse counterpart of the 2-to-4 decoder.
module prio_pick4
    import encoder_4x2_pkg::*;
(
    input  logic [0:NREQ-1]   req_i,
    input  logic [CODE_W-1:0] start_i,
    output logic [CODE_W-1:0] idx_o,
    output logic              found_o
);

    logic [CODE_W-1:0] pos;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = start_i + CODE_W'(k);
            if (!found_o && req_i[pos]) begin
                idx_o   = pos;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_4x2.sv
// Registered 4-to-2 request encoder with pending set and valid/ack handoff.
// Define ENCODER_4X2_ROUND_ROBIN_EN for round-robin selection.
module encoder_4x2
    import encoder_4x2_pkg::*;
#(
    parameter logic [0:1] IDLE_CODE = IDLE_CODE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:3]    req_in,
    input  logic          load,
    output logic [0:1]    code,
    output logic          valid,
    input  logic          ack,
    output logic [0:3]    pending,
    output logic          busy
);

    logic [0:NREQ-1]   pend_q, pend_d, merged;
    logic [0:1]        code_q, code_d;
    logic [0:0]        state_q, state_d;
    logic [CODE_W-1:0] start, pick_idx;
    logic              pick_found, upd;

`ifdef ENCODER_4X2_ROUND_ROBIN_EN
    logic [CODE_W-1:0] ptr_q, ptr_d;
    assign start = ptr_q + 1'b1;
`else
    assign start = '0;
`endif

    prio_pick4 u_pick (
        .req_i   (merged),
        .start_i (start),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Merge precedes selection so a same-edge load can win the next grant
    assign merged = pend_q | (load ? req_in : '0);
    assign upd    = (state_q == ST_IDLE) || ack;

    always_comb begin
        pend_d  = merged;
        code_d  = code_q;
        state_d = state_q;
`ifdef ENCODER_4X2_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        if (upd) begin
            if (pick_found) begin
                pend_d[pick_idx] = 1'b0;
                code_d           = idx_to_code(pick_idx);
                state_d          = ST_GRANT;
`ifdef ENCODER_4X2_ROUND_ROBIN_EN
                ptr_d            = pick_idx;
`endif
            end else begin
                code_d  = IDLE_CODE;
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            code_q  <= IDLE_CODE;
            state_q <= ST_IDLE;
`ifdef ENCODER_4X2_ROUND_ROBIN_EN
            ptr_q   <= 2'd3;
`endif
        end else begin
            pend_q  <= pend_d;
            code_q  <= code_d;
            state_q <= state_d;
`ifdef ENCODER_4X2_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign code    = code_q;
    assign valid   = (state_q == ST_GRANT);
    assign pending = pend_q;
    assign busy    = valid | (|pend_q);

endmodule

// File: tb/tb_encoder_4x2.sv
// Directed self-checking bench for encoder_4x2.
// Honors ENCODER_4X2_ROUND_ROBIN_EN for the arbitration-order vectors.
module tb_encoder_4x2;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] req_in;
    logic       load;
    logic [0:1] code;
    logic       valid;
    logic       ack;
    logic [0:3] pending;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    encoder_4x2 dut (
        .clk     (clk),
        .rst     (rst),
        .req_in  (req_in),
        .load    (load),
        .code    (code),
        .valid   (valid),
        .ack     (ack),
        .pending (pending),
        .busy    (busy)
    );

    function automatic logic [0:1] cv(input logic [1:0] i);
        logic [0:1] c;
        c[0] = i[0];
        c[1] = i[1];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v,
                           input logic [0:1] c, input logic [0:3] p,
                           input logic b);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".code"}, 32'(code), 32'(c));
        chk({tag, ".pending"}, 32'(pending), 32'(p));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; ack = 1'b0; req_in = '0;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_seq [6];
    logic       exp_vld [6];

    initial begin
        rst = 1'b1; load = 1'b0; ack = 1'b0; req_in = '0;

        // Reset state
        do_reset();
        chk_all("reset", 1'b0, 2'b00, 4'b0000, 1'b0);

        // Load bits 1,2 with no ack: grant 1, bit 2 held pending
        load = 1'b1; req_in = 4'b0110;
        tick();
        load = 1'b0; req_in = '0;
        chk_all("ld0110", 1'b1, cv(2'd1), 4'b0010, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("hold%0d", i), 1'b1, cv(2'd1), 4'b0010, 1'b1);
        end
        ack = 1'b1;
        tick();
        chk_all("ack1", 1'b1, cv(2'd2), 4'b0000, 1'b1);
        tick();
        chk_all("ack2", 1'b0, 2'b00, 4'b0000, 1'b0);
        ack = 1'b0;

        // All four with ack held: one grant per cycle
        do_reset();
        load = 1'b1; req_in = 4'b1111; ack = 1'b1;
        tick();
        load = 1'b0; req_in = '0;
        chk_all("b2b0", 1'b1, cv(2'd0), 4'b0111, 1'b1);
        tick();
        chk_all("b2b1", 1'b1, cv(2'd1), 4'b0011, 1'b1);
        tick();
        chk_all("b2b2", 1'b1, cv(2'd2), 4'b0001, 1'b1);
        tick();
        chk_all("b2b3", 1'b1, cv(2'd3), 4'b0000, 1'b1);
        tick();
        chk_all("b2bend", 1'b0, 2'b00, 4'b0000, 1'b0);
        ack = 1'b0;

        // Higher-priority load must not preempt an unacked grant
        do_reset();
        load = 1'b1; req_in = 4'b0010;
        tick();
        chk_all("g2", 1'b1, cv(2'd2), 4'b0000, 1'b1);
        req_in = 4'b1000;
        tick();
        load = 1'b0; req_in = '0;
        chk_all("nopre", 1'b1, cv(2'd2), 4'b1000, 1'b1);
        ack = 1'b1;
        tick();
        chk_all("after_ack", 1'b1, cv(2'd0), 4'b0000, 1'b1);

        // Same-edge load of bit 3 and ack with empty pending
        load = 1'b1; req_in = 4'b0001;
        tick();
        load = 1'b0; req_in = '0;
        chk_all("ldack3", 1'b1, cv(2'd3), 4'b0000, 1'b1);
        tick();
        chk_all("ldack3_end", 1'b0, 2'b00, 4'b0000, 1'b0);
        ack = 1'b0;

        // Ack while idle is ignored
        ack = 1'b1;
        tick();
        chk_all("idle_ack", 1'b0, 2'b00, 4'b0000, 1'b0);
        ack = 1'b0;

        // Mid-operation reset with three pending; load/ack ignored
        do_reset();
        load = 1'b1; req_in = 4'b1111;
        tick();
        chk_all("pre_rst", 1'b1, cv(2'd0), 4'b0111, 1'b1);
        rst = 1'b1; ack = 1'b1;
        tick();
        chk_all("mid_rst", 1'b0, 2'b00, 4'b0000, 1'b0);
        rst = 1'b0; load = 1'b0; req_in = '0;
        tick();
        chk_all("post_rst_ack", 1'b0, 2'b00, 4'b0000, 1'b0);
        ack = 1'b0;

        // Re-asserting the granted bit queues it again; load of 0 is no-op
        do_reset();
        load = 1'b1; req_in = 4'b0100;
        tick();
        chk_all("g1", 1'b1, cv(2'd1), 4'b0000, 1'b1);
        tick();
        chk_all("reassert", 1'b1, cv(2'd1), 4'b0100, 1'b1);
        req_in = 4'b0000;
        tick();
        load = 1'b0;
        chk_all("ld_zero", 1'b1, cv(2'd1), 4'b0100, 1'b1);
        ack = 1'b1;
        tick();
        chk_all("reserve", 1'b1, cv(2'd1), 4'b0000, 1'b1);
        tick();
        chk_all("reserve_end", 1'b0, 2'b00, 4'b0000, 1'b0);
        ack = 1'b0;

        // Bits 0 and 3 reloaded every edge with ack held
`ifdef ENCODER_4X2_ROUND_ROBIN_EN
        exp_seq = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
        exp_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        exp_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
        do_reset();
        ack = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load = (i < 4);
            req_in = (i < 4) ? 4'b1001 : 4'b0000;
            tick();
            chk($sformatf("arb%0d.valid", i), 32'(valid), 32'(exp_vld[i]));
            chk($sformatf("arb%0d.code", i), 32'(code),
                32'(exp_vld[i] ? cv(exp_seq[i]) : 2'b00));
        end
        load = 1'b0; ack = 1'b0; req_in = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
